// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants for the branch resolution unit
//
// Purpose: funct3 encodings of the RV32I conditional branches, the
// datapath width and the sequential PC step, shared by branch_cmp and
// branch_resolve.
// Ports: none (package).

package branch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluator
//
// Purpose: decides the direction of an RV32I conditional branch.
// Ports:
//   rs1_i, rs2_i   operand values
//   funct3_i       branch condition encoding
//   taken_o        condition holds (always 0 for reserved encodings)
//   illegal_o      funct3 is one of the reserved encodings 010/011

module branch_cmp
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BLT:  taken_o = lt_s;
      BR_BGE:  taken_o = !lt_s;
      BR_BLTU: taken_o = lt_u;
      BR_BGEU: taken_o = !lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution with registered result
//
// Purpose: evaluates a decoded conditional branch, computes its target,
// holds the result in a single output register behind valid/ready and
// raises a one-cycle redirect toward fetch when the prediction was wrong.
// Optional feature macro: BRANCH_STATS_EN (adds transfer statistics ports).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   kill held result and any same-cycle input
//   in_valid / in_ready     upstream handshake
//   in_pc, in_rs1, in_rs2   branch PC and operands
//   in_funct3, in_imm       condition and raw B-type immediate {imm[12:1],0}
//   in_pred_taken           direction predicted by fetch
//   out_valid / out_ready   downstream handshake
//   out_pc, out_taken, out_target, out_illegal, out_misalign  registered result
//   redirect, redirect_pc   mispredict pulse and corrected next PC
//   stat_branches, stat_taken, stat_mispred  (BRANCH_STATS_EN only)

module branch_resolve
  import branch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [12:0]     in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic            out_misalign,
  output logic            redirect,
`ifdef BRANCH_STATS_EN
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_taken,
  output logic [XLEN-1:0] stat_mispred
`else
  output logic [XLEN-1:0] redirect_pc
`endif
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic            illegal_q;
  logic            misalign_q;
  logic            pred_q;

  logic            taken_d;
  logic            illegal_d;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] target_d;
  logic            misalign_d;
  logic            accept;
  logic            xfer;

  branch_cmp u_cmp (
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .funct3_i  (in_funct3),
    .taken_o   (taken_d),
    .illegal_o (illegal_d)
  );

  // imm[0] is architecturally zero; it is masked rather than trusted.
  assign imm_sext   = {{(XLEN-13){in_imm[12]}}, in_imm[12:1], in_imm[0] & 1'b0};
  assign target_d   = in_pc + imm_sext;
  assign misalign_d = taken_d & target_d[1];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // A flushed result is killed, so it never counts as delivered.
  assign xfer     = valid_q && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      taken_q    <= 1'b0;
      target_q   <= RESET_PC;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end

      if (accept) begin
        pc_q       <= in_pc;
        taken_q    <= taken_d;
        target_q   <= target_d;
        illegal_q  <= illegal_d;
        misalign_q <= misalign_d;
        pred_q     <= in_pred_taken;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_taken    = taken_q;
  assign out_target   = target_q;
  assign out_illegal  = illegal_q;
  assign out_misalign = misalign_q;

  assign redirect = xfer && !illegal_q && !misalign_q && (taken_q != pred_q);

  // With no result held the register contents are reported as-is, so the
  // reset value of redirect_pc is RESET_PC rather than RESET_PC + 4.
  always_comb begin
    redirect_pc = pc_q;
    if (valid_q) begin
      redirect_pc = taken_q ? target_q : (pc_q + PC_STEP);
    end
  end

`ifdef BRANCH_STATS_EN
  logic [XLEN-1:0] stat_branches_q;
  logic [XLEN-1:0] stat_taken_q;
  logic [XLEN-1:0] stat_mispred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (xfer) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      // Illegal results always carry taken = 0, so they land in branches only.
      if (xfer && taken_q) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end
      if (redirect) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard testbench for branch_resolve

module tb_branch_resolve;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [12:0] in_imm = '0;
  logic        in_pred_taken = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_illegal;
  logic        out_misalign;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_mispred;
`endif

  branch_resolve #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_funct3     (in_funct3),
    .in_imm        (in_imm),
    .in_pred_taken (in_pred_taken),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_taken     (out_taken),
    .out_target    (out_target),
    .out_illegal   (out_illegal),
    .out_misalign  (out_misalign),
    .redirect      (redirect),
`ifdef BRANCH_STATS_EN
    .redirect_pc   (redirect_pc),
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken),
    .stat_mispred  (stat_mispred)
`else
    .redirect_pc   (redirect_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] rpc;
    logic        taken;
    logic        ill;
    logic        mis;
    logic        redir;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_ready = 1'b0;
  int   st_br = 0;
  int   st_tk = 0;
  int   st_mp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [2:0] f3,
                                 input logic [12:0] imm, input logic pred);
    exp_t e;
    logic [31:0] off;
    off = {{19{imm[12]}}, imm[12:1], 1'b0};
    e.pc     = pc;
    e.target = pc + off;
    e.ill    = 1'b0;
    case (f3)
      3'b000: e.taken = (rs1 == rs2);
      3'b001: e.taken = (rs1 != rs2);
      3'b100: e.taken = ($signed(rs1) < $signed(rs2));
      3'b101: e.taken = ($signed(rs1) >= $signed(rs2));
      3'b110: e.taken = (rs1 < rs2);
      3'b111: e.taken = (rs1 >= rs2);
      default: begin
        e.taken = 1'b0;
        e.ill   = 1'b1;
      end
    endcase
    e.mis   = e.taken & e.target[1];
    e.redir = !e.ill && !e.mis && (e.taken != pred);
    e.rpc   = e.taken ? e.target : pc + 32'd4;
    return e;
  endfunction

  // Monitor: every transfer pops one expected result; any other cycle must be redirect-free.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
          check("out_target", out_target, e.target);
          check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
          check("out_misalign", {31'd0, out_misalign}, {31'd0, e.mis});
          check("redirect", {31'd0, redirect}, {31'd0, e.redir});
          if (e.redir) check("redirect_pc", redirect_pc, e.rpc);
          st_br++;
          if (e.taken) st_tk++;
          if (e.redir) st_mp++;
        end
      end else begin
        check("redirect_idle", {31'd0, redirect}, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [2:0] f3, input logic [12:0] imm, input logic pred);
    bit done = 1'b0;
    int budget = 0;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm; in_pred_taken = pred;
    in_valid = 1'b1;
    while (!done) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready && !flush) begin
        sb.push_back(model(pc, rs1, rs2, f3, imm, pred));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      budget++;
      if (!done && budget > 100) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  logic [31:0] snap_pc;
  logic [31:0] snap_tgt;
  logic        snap_tk;

  initial begin
    // Reset values
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, RST_PC);
    check("rst_out_target", out_target, RST_PC);
    check("rst_redirect_pc", redirect_pc, RST_PC);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_taken", {31'd0, out_taken}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, back to back with out_ready high
    send(32'h100, 32'd5, 32'd5, 3'b000, 13'h010, 1'b0);             // BEQ taken, redirect 0x110
    send(32'h200, 32'hFFFF_FFFF, 32'd1, 3'b100, 13'h010, 1'b1);      // BLT taken
    send(32'h200, 32'hFFFF_FFFF, 32'd1, 3'b110, 13'h010, 1'b1);      // BLTU not taken, rpc 0x204
    send(32'h4, 32'd0, 32'd1, 3'b001, 13'h1FF8, 1'b0);               // backward wrap to FFFF_FFFC
    send(32'h100, 32'd7, 32'd7, 3'b000, 13'h002, 1'b0);              // misaligned target
    send(32'h100, 32'd1, 32'd2, 3'b010, 13'h010, 1'b1);              // illegal funct3
    send(32'h300, 32'd1, 32'd2, 3'b011, 13'h020, 1'b0);              // illegal funct3
    send(32'h300, 32'h8000_0000, 32'd0, 3'b101, 13'h021, 1'b1);      // BGE not taken, imm[0] ignored
    send(32'hFFFF_FFFC, 32'd3, 32'd3, 3'b111, 13'h040, 1'b1);        // BGEU taken, add wraps
    send(32'hFFFF_FFFC, 32'd3, 32'd4, 3'b111, 13'h040, 1'b1);        // BGEU not taken, pc+4 wraps
    drain();

    // Randomised traffic with downstream backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      send({$urandom_range(0, 32'h3FFF), 2'b00}, a, b, 3'($urandom_range(0, 7)),
           13'($urandom()), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    drain();

    // Stall: outputs frozen and in_ready low for 3 cycles
    out_ready = 1'b0;
    send(32'h500, 32'd9, 32'd9, 3'b000, 13'h100, 1'b1);
    snap_pc = out_pc; snap_tgt = out_target; snap_tk = out_taken;
    check("stall_loaded_pc", snap_pc, 32'h500);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_pc", out_pc, snap_pc);
      check("stall_target", out_target, snap_tgt);
      check("stall_taken", {31'd0, out_taken}, {31'd0, snap_tk});
      @(posedge clk); #1;
    end

    // Flush with a same-cycle input: both the held result and the input die
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_pc = 32'h600; in_funct3 = 3'b000; in_rs1 = 0; in_rs2 = 0; in_pred_taken = 1'b0;
    @(negedge clk);
    check("flush_redirect", {31'd0, redirect}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Reset asserted mid-stall
    out_ready = 1'b0;
    send(32'h700, 32'd1, 32'd2, 3'b100, 13'h010, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_pc", out_pc, RST_PC);
    check("midrst_out_target", out_target, RST_PC);
    check("midrst_redirect_pc", redirect_pc, RST_PC);
    check("midrst_taken", {31'd0, out_taken}, 32'd0);
    check("midrst_redirect", {31'd0, redirect}, 32'd0);
    sb.delete();
    st_br = 0; st_tk = 0; st_mp = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Four transfers: 2 taken, 1 mispredicted
    send(32'h800, 32'd1, 32'd1, 3'b000, 13'h010, 1'b1);  // taken, predicted
    send(32'h804, 32'd1, 32'd2, 3'b000, 13'h010, 1'b0);  // not taken, predicted
    send(32'h808, 32'd2, 32'd1, 3'b101, 13'h010, 1'b0);  // taken, mispredicted
    send(32'h80C, 32'd1, 32'd2, 3'b010, 13'h010, 1'b1);  // illegal
    drain();
    @(posedge clk); #1;
    check("post_rst_mispred_model", st_mp, 32'd1);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, st_br);
    check("stat_taken", stat_taken, st_tk);
    check("stat_mispred", stat_mispred, st_mp);
    check("stat_branches_4", stat_branches, 32'd4);
    check("stat_taken_2", stat_taken, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the RV32I pipeline. Accepts a decoded conditional branch (PC, operand values, funct3, raw 13-bit B-type immediate, predicted direction), evaluates the condition, and computes the sign-extended target. The result is registered behind a valid/ready handshake. A one-cycle redirect pulse is raised toward fetch on misprediction. The unit sits between decode/operand read and the writeback/commit stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: value of `out_pc` and `redirect_pc` in reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill the held result and any same-cycle input.
- `in_valid`  in  1  upstream branch valid.
- `in_ready`  out  1  unit can accept.
- `in_pc`  in  32  branch instruction PC.
- `in_rs1`, `in_rs2`  in  32 each  operand values.
- `in_funct3`  in  3  branch condition.
- `in_imm`  in  13  B-type immediate {imm[12:1],0}.
- `in_pred_taken`  in  1  fetch prediction.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  32  registered `in_pc`.
- `out_taken`  out  1  resolved direction.
- `out_target`  out  32  `in_pc` + sext(`in_imm`).
- `out_illegal`  out  1  funct3 is 010 or 011.
- `out_misalign`  out  1  taken with target[1] = 1.
- `redirect`  out  1  mispredict pulse.
- `redirect_pc`  out  32  correct next PC.

## Operation
- Conditions:
  - 000 BEQ, 001 BNE: equality.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010, 011: `out_illegal` = 1, taken = 0.
- Target:
  - `in_imm[0]` is ignored and forced to 0.
  - Bit 12 is replicated into bits 31:13.
  - The 32-bit add wraps modulo 2^32 (e.g. PC 0x0000_0004 + imm 0x1FF8 (-8) = 0xFFFF_FFFC).
- `out_misalign` = taken & target[1]. When it is set, no redirect is raised; exception handling is downstream.
- Handshake:
  - `in_ready` = !`out_valid` | `out_ready`.
  - Input accepted when `in_valid` & `in_ready` & !`flush`.
  - The output register holds stable while `out_valid` & !`out_ready`.
- Redirect:
  - `redirect` = `out_valid` & `out_ready` & !`out_illegal` & !`out_misalign` & (`out_taken` != predicted).
  - `redirect_pc` = `out_taken` ? `out_target` : `out_pc` + 4. The +4 wraps.
- Flush:
  - Clears `out_valid` on the next edge, and suppresses `redirect` in the same cycle.
  - Takes priority over a simultaneous accept, which is dropped.
- Reset:
  - `out_valid`, `out_taken`, `out_illegal`, `out_misalign`, `redirect` = 0.
  - `out_pc` = `out_target` = `redirect_pc` = `RESET_PC`.
  - Reset asserted mid-transfer discards the held result.

## Timing
- Latency 1 cycle: accept at edge N, `out_valid` high after edge N.
- Throughput 1 per cycle when `out_ready` is held high. Back-to-back accept and transfer in the same cycle is legal.
- `redirect` and `redirect_pc` are combinational from the output register and `out_ready`. They are high only in the transfer cycle, never repeated.
- Under stall, every output is constant until transfer or flush.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output ports `stat_branches`, `stat_taken`, `stat_mispred`, each 32 bits.
  - Each counter increments on output transfers: all branches, taken branches, and redirect cycles respectively.
  - Counters wrap at 2^32, reset to 0, and are not cleared by `flush`.
  - Illegal branches count in `stat_branches` only.
- Not defined: the ports and counters do not exist, and all other behaviour is identical.

## Structure
- Shared package `branch_pkg`:
  - funct3 localparams `BR_BEQ`..`BR_BGEU`.
  - `PC_STEP` = 4.
  - Width constant `XLEN` = 32.
- One sub-module, `branch_cmp`: combinational, takes rs1, rs2 and funct3, and produces taken and illegal.
- The top level holds the target adder, the output register, the handshake logic and the optional counters.

## Test plan
- BEQ taken:
  - Stimulus: PC 0x100, rs1 = rs2 = 5, imm 0x010, pred 0.
  - Response: next cycle taken = 1, target 0x110. With `out_ready` = 1, redirect pulses once with `redirect_pc` 0x110.
- BLT vs BLTU:
  - Stimulus: rs1 0xFFFF_FFFF, rs2 1.
  - Response: BLT taken = 1; BLTU taken = 0. PC 0x200, pred 1 on BLTU gives `redirect_pc` 0x204.
- Backward target:
  - Stimulus: PC 0x4, imm 0x1FF8, BNE with rs1 0, rs2 1.
  - Response: target 0xFFFF_FFFC, `out_misalign` = 0.
- Misaligned target:
  - Stimulus: PC 0x100, imm 0x002, taken BEQ.
  - Response: `out_misalign` = 1, no redirect.
- Illegal funct3:
  - Stimulus: funct3 010.
  - Response: `out_illegal` = 1, taken = 0, no redirect.
- Stall, flush and reset:
  - Hold `out_ready` = 0 for 3 cycles: outputs stable, `in_ready` = 0.
  - Assert `flush` with `in_valid` = 1: `out_valid` = 0 next cycle, input dropped.
  - Drop `rst_n` mid-stall: all outputs at reset values immediately.
  - With `BRANCH_STATS_EN` defined, after 4 transfers (2 taken, 1 mispredicted): counters read 4/2/1.
